starbug_vliw_regfile: RTL and testbench

Shared multi-ported integer register file for the STARBUG VLIW core. It is the responder to each lane datapath's relayed register-file interface (a1/a2 read addresses, rd1/rd2 read data, we3/a3/wd3 writeback). It serves 2 read ports and 1 write port per lane, resolves same-cycle write collisions by lane priority, and provides write-to-read bypass so a Writeback-stage result is visible to Decode in the same cycle.

---
 rtl/starbug_vliw_regfile_pkg.sv | 14 +
 rtl/starbug_rf_readport.sv | 35 +++
 rtl/starbug_vliw_regfile.sv | 108 ++++++++++
 tb/tb_starbug_vliw_regfile.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/starbug_vliw_regfile_pkg.sv
// Shared constants and helpers for the STARBUG VLIW register file and forwarding logic.
package starbug_vliw_regfile_pkg;

    localparam int unsigned STARBUG_LANES = 4;

    // Lane i occupies bits [5i+4:5i] of an address bus and [XLEN*i+XLEN-1:XLEN*i] of a data bus.
    typedef logic [$clog2(STARBUG_LANES)-1:0] lane_idx_t;

    // Under RV32E/64E only 16 registers exist, so bit 4 is dropped (x16 aliases x0, x17 x1, ...).
    function automatic logic [4:0] eff_addr(input logic [4:0] a, input logic e_mode);
        return e_mode ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/starbug_rf_readport.sv
// One combinational read port: address masking, x0 zeroing and same-cycle writeback bypass.
module starbug_rf_readport
    import starbug_vliw_regfile_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned E_SUPPORTED = 0,
    parameter int unsigned LANES       = STARBUG_LANES
) (
    input  logic [4:0]            addr,
    input  logic [XLEN-1:0]       stored,
    input  logic [LANES-1:0]      we3,
    input  logic [LANES*5-1:0]    a3,
    input  logic [LANES*XLEN-1:0] wd3,
    output logic [XLEN-1:0]       rdata
);

    localparam logic EMode = (E_SUPPORTED != 0);

    logic [4:0] ea;

    always_comb begin
        ea    = eff_addr(addr, EMode);
        rdata = stored;
        // Ascending scan so the highest-numbered writing lane ends up on the port.
        for (int l = 0; l < int'(LANES); l++) begin
            if (we3[l] && (eff_addr(a3[5*l +: 5], EMode) == ea)) begin
                rdata = wd3[XLEN*l +: XLEN];
            end
        end
        if (ea == 5'd0) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/starbug_vliw_regfile.sv
// Shared multi-ported integer register file: 2 reads and 1 write per lane, lane-priority writes,
// write-to-read bypass and write-collision flags.
module starbug_vliw_regfile
    import starbug_vliw_regfile_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned E_SUPPORTED = 0,
    parameter int unsigned LANES       = STARBUG_LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES*5-1:0]    a1,
    input  logic [LANES*5-1:0]    a2,
    output logic [LANES*XLEN-1:0] rd1,
    output logic [LANES*XLEN-1:0] rd2,
    input  logic [LANES-1:0]      we3,
    input  logic [LANES*5-1:0]    a3,
    input  logic [LANES*XLEN-1:0] wd3,
    output logic                  WriteConflictW,
    output logic                  WriteConflictSticky
);

    localparam int unsigned NREGS = (E_SUPPORTED != 0) ? 16 : 32;
    localparam logic        EMode = (E_SUPPORTED != 0);

    // x0 has no storage.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic            conflict;
    logic            hit;

    always_comb begin
        regs_d   = regs_q;
        conflict = 1'b0;
        hit      = 1'b0;
        for (int r = 1; r < int'(NREGS); r++) begin
            hit = 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                if (we3[l] && (eff_addr(a3[5*l +: 5], EMode) == 5'(r))) begin
                    if (hit) begin
                        conflict = 1'b1;
                    end
                    hit       = 1'b1;
                    regs_d[r] = wd3[XLEN*l +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 1; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
            WriteConflictW      <= 1'b0;
            WriteConflictSticky <= 1'b0;
        end else begin
            regs_q              <= regs_d;
            WriteConflictW      <= conflict;
            WriteConflictSticky <= WriteConflictSticky | conflict;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [XLEN-1:0] stored1;
        logic [XLEN-1:0] stored2;

        always_comb begin
            stored1 = '0;
            stored2 = '0;
            for (int r = 1; r < int'(NREGS); r++) begin
                if (eff_addr(a1[5*l +: 5], EMode) == 5'(r)) begin
                    stored1 = regs_q[r];
                end
                if (eff_addr(a2[5*l +: 5], EMode) == 5'(r)) begin
                    stored2 = regs_q[r];
                end
            end
        end

        starbug_rf_readport #(
            .XLEN       (XLEN),
            .E_SUPPORTED(E_SUPPORTED),
            .LANES      (LANES)
        ) u_rp1 (
            .addr  (a1[5*l +: 5]),
            .stored(stored1),
            .we3   (we3),
            .a3    (a3),
            .wd3   (wd3),
            .rdata (rd1[XLEN*l +: XLEN])
        );

        starbug_rf_readport #(
            .XLEN       (XLEN),
            .E_SUPPORTED(E_SUPPORTED),
            .LANES      (LANES)
        ) u_rp2 (
            .addr  (a2[5*l +: 5]),
            .stored(stored2),
            .we3   (we3),
            .a3    (a3),
            .wd3   (wd3),
            .rdata (rd2[XLEN*l +: XLEN])
        );
    end

endmodule

// File: tb/tb_starbug_vliw_regfile.sv
// Self-checking bench for starbug_vliw_regfile: directed table, random traffic against a
// reference model, and an RV64E instance for address aliasing.
module tb_starbug_vliw_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [3:0][4:0]   a1, a2, a3;
    logic [3:0]        we3;
    logic [3:0][63:0]  wd3, rd1, rd2;
    logic              cw, st;

    logic [3:0][4:0]   e_a1, e_a2, e_a3;
    logic [3:0]        e_we3;
    logic [3:0][63:0]  e_wd3, e_rd1, e_rd2;
    logic              e_cw, e_st;

    starbug_vliw_regfile #(.XLEN(64), .E_SUPPORTED(0), .LANES(4)) u_dut (
        .clk                (clk),
        .reset              (reset),
        .a1                 (a1),
        .a2                 (a2),
        .rd1                (rd1),
        .rd2                (rd2),
        .we3                (we3),
        .a3                 (a3),
        .wd3                (wd3),
        .WriteConflictW     (cw),
        .WriteConflictSticky(st)
    );

    starbug_vliw_regfile #(.XLEN(64), .E_SUPPORTED(1), .LANES(4)) u_dut_e (
        .clk                (clk),
        .reset              (reset),
        .a1                 (e_a1),
        .a2                 (e_a2),
        .rd1                (e_rd1),
        .rd2                (e_rd2),
        .we3                (e_we3),
        .a3                 (e_a3),
        .wd3                (e_wd3),
        .WriteConflictW     (e_cw),
        .WriteConflictSticky(e_st)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents and flags.
    logic [63:0] mem [32];
    logic        m_cw, m_st;

    typedef struct {
        logic             rst;
        logic [3:0]       we;
        logic [3:0][4:0]  wa;
        logic [3:0][63:0] wd;
        logic [3:0][4:0]  ra1;
        logic [3:0][4:0]  ra2;
        int               lane;
        logic [63:0]      e1;
        logic [63:0]      e2;
        logic             ecw;
        logic             est;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        logic [63:0] v;
        if (a == 5'd0) return 64'd0;
        v = mem[a];
        for (int l = 0; l < 4; l++) begin
            if (we3[l] && a3[l] == a) v = wd3[l];
        end
        return v;
    endfunction

    function automatic void model_edge();
        int cnt [32];
        if (!reset) begin
            foreach (mem[i]) mem[i] = 64'd0;
            m_cw = 1'b0;
            m_st = 1'b0;
        end else begin
            foreach (cnt[i]) cnt[i] = 0;
            for (int l = 0; l < 4; l++) begin
                if (we3[l] && a3[l] != 5'd0) begin
                    mem[a3[l]] = wd3[l];
                    cnt[a3[l]]++;
                end
            end
            m_cw = 1'b0;
            foreach (cnt[i]) if (cnt[i] > 1) m_cw = 1'b1;
            m_st = m_st | m_cw;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all();
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("model rd1[%0d] a=%0d", l, a1[l]), rd1[l], exp_rd(a1[l]));
            chk($sformatf("model rd2[%0d] a=%0d", l, a2[l]), rd2[l], exp_rd(a2[l]));
        end
        chk("model WriteConflictW", {63'd0, cw}, {63'd0, m_cw});
        chk("model WriteConflictSticky", {63'd0, st}, {63'd0, m_st});
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.rst = 1'b1; v.we = '0; v.wa = '0; v.wd = '0; v.ra1 = '0; v.ra2 = '0;
        v.lane = 0; v.e1 = '0; v.e2 = '0; v.ecw = 1'b0; v.est = 1'b0;
        return v;
    endfunction

    task automatic idle_main();
        we3 = '0; a3 = '0; wd3 = '0; a1 = '0; a2 = '0;
    endtask

    task automatic idle_e();
        e_we3 = '0; e_a3 = '0; e_wd3 = '0; e_a1 = '0; e_a2 = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_main();
        idle_e();
        repeat (2) tick();

        for (int i = 0; i < 11; i++) tbl[i] = blank();
        // Write under reset is bypassed but discarded.
        tbl[0].rst = 1'b0; tbl[0].we = 4'b0001; tbl[0].wa[0] = 5'd5; tbl[0].wd[0] = 64'hDEAD;
        tbl[0].ra1[0] = 5'd5; tbl[0].e1 = 64'hDEAD;
        tbl[1].ra1[0] = 5'd5; tbl[1].e1 = 64'd0;
        tbl[2].we = 4'b0001; tbl[2].wa[0] = 5'd5; tbl[2].wd[0] = 64'h1234;
        tbl[2].ra1[2] = 5'd5; tbl[2].lane = 2; tbl[2].e1 = 64'h1234;
        tbl[3].ra1[2] = 5'd5; tbl[3].lane = 2; tbl[3].e1 = 64'h1234;
        tbl[4].we = 4'b1010; tbl[4].wa[1] = 5'd7; tbl[4].wa[3] = 5'd7;
        tbl[4].wd[1] = 64'hAAAA; tbl[4].wd[3] = 64'hBBBB;
        tbl[4].ra1[0] = 5'd5; tbl[4].ra2[0] = 5'd7; tbl[4].e1 = 64'h1234; tbl[4].e2 = 64'hBBBB;
        tbl[5].ra2[0] = 5'd7; tbl[5].e2 = 64'hBBBB; tbl[5].ecw = 1'b1; tbl[5].est = 1'b1;
        tbl[6].ra2[0] = 5'd7; tbl[6].e2 = 64'hBBBB; tbl[6].est = 1'b1;
        tbl[7].we = 4'b1111; tbl[7].wd = {4{64'hFFFF}};
        tbl[7].ra2[0] = 5'd7; tbl[7].e2 = 64'hBBBB; tbl[7].est = 1'b1;
        tbl[8].ra2[0] = 5'd7; tbl[8].e2 = 64'hBBBB; tbl[8].est = 1'b1;
        tbl[9].rst = 1'b0; tbl[9].we = 4'b0001; tbl[9].wa[0] = 5'd9; tbl[9].wd[0] = 64'h77;
        tbl[9].ra1[0] = 5'd9; tbl[9].e1 = 64'h77; tbl[9].ra2[0] = 5'd7; tbl[9].e2 = 64'hBBBB;
        tbl[9].est = 1'b1;
        tbl[10].ra1[0] = 5'd9; tbl[10].ra2[0] = 5'd7;

        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst; we3 = tbl[i].we; a3 = tbl[i].wa; wd3 = tbl[i].wd;
            a1 = tbl[i].ra1; a2 = tbl[i].ra2;
            @(negedge clk);
            check_all();
            chk($sformatf("tbl%0d rd1[%0d]", i, tbl[i].lane), rd1[tbl[i].lane], tbl[i].e1);
            chk($sformatf("tbl%0d rd2[%0d]", i, tbl[i].lane), rd2[tbl[i].lane], tbl[i].e2);
            chk($sformatf("tbl%0d WriteConflictW", i), {63'd0, cw}, {63'd0, tbl[i].ecw});
            chk($sformatf("tbl%0d WriteConflictSticky", i), {63'd0, st}, {63'd0, tbl[i].est});
            tick();
        end

        // After reset, every register reads zero on every port.
        idle_main();
        for (int r = 0; r < 32; r++) begin
            for (int l = 0; l < 4; l++) begin
                a1[l] = 5'(r);
                a2[l] = 5'(r);
            end
            @(negedge clk);
            for (int l = 0; l < 4; l++) begin
                chk($sformatf("zero rd1[%0d] x%0d", l, r), rd1[l], 64'd0);
                chk($sformatf("zero rd2[%0d] x%0d", l, r), rd2[l], 64'd0);
            end
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 29) != 0);
            we3 = 4'($urandom);
            for (int l = 0; l < 4; l++) begin
                a3[l]  = 5'($urandom_range(0, 7));
                wd3[l] = {$urandom, $urandom};
                a1[l]  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                a2[l]  = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
            check_all();
            tick();
        end

        // RV64E instance: bit 4 of every address is ignored.
        idle_main();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        e_we3 = 4'b0001; e_a3[0] = 5'd17; e_wd3[0] = 64'h55; e_a1[0] = 5'd1; e_a2[0] = 5'd17;
        @(negedge clk);
        chk("E bypass x17->x1 rd1", e_rd1[0], 64'h55);
        chk("E bypass x17->x1 rd2", e_rd2[0], 64'h55);
        tick();
        idle_e();
        e_a1[0] = 5'd1;
        @(negedge clk);
        chk("E array x1", e_rd1[0], 64'h55);
        chk("E no conflict", {63'd0, e_cw}, 64'd0);
        tick();
        e_we3 = 4'b0001; e_a3[0] = 5'd16; e_wd3[0] = 64'h99; e_a1[0] = 5'd16; e_a1[1] = 5'd1;
        @(negedge clk);
        chk("E write x16 bypass", e_rd1[0], 64'd0);
        chk("E x1 kept", e_rd1[1], 64'h55);
        tick();
        idle_e();
        e_a1[0] = 5'd0; e_a1[1] = 5'd1; e_a2[1] = 5'd16;
        @(negedge clk);
        chk("E x0 after x16 write", e_rd1[0], 64'd0);
        chk("E x1 after x16 write", e_rd1[1], 64'h55);
        chk("E x16 reads x0", e_rd2[1], 64'd0);
        chk("E sticky clear", {63'd0, e_st}, 64'd0);
        tick();
        e_we3 = 4'b0011; e_a3[0] = 5'd3; e_a3[1] = 5'd19; e_wd3[0] = 64'h11; e_wd3[1] = 64'h22;
        e_a1[0] = 5'd3;
        @(negedge clk);
        chk("E alias collision bypass", e_rd1[0], 64'h22);
        tick();
        idle_e();
        e_a1[0] = 5'd3;
        @(negedge clk);
        chk("E alias collision stored", e_rd1[0], 64'h22);
        chk("E alias collision pulse", {63'd0, e_cw}, 64'd1);
        chk("E alias collision sticky", {63'd0, e_st}, 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
